// File: rtl/sdram_client_arbiter.sv
// sdram_client_arbiter: multiplexes NUM_CLIENTS toggle-handshake clients onto
// a single toggle-handshake SDRAM controller port.
//
// Handshake: a client is pending while cl_req[i] != cl_ack[i]. The SDRAM access
// is outstanding while sdr_req != sdr_ack. A grant toggles sdr_req; completion
// is seen when sdr_ack catches up. There is no valid/ready pair and no extra
// backpressure beyond these toggles.
// busy mirrors the FSM state (1 = WAIT) and grant_id names the served client,
// so both stay observable from outside.
module sdram_client_arbiter #(
  parameter int NUM_CLIENTS = 3,
  parameter int ADDR_W      = 26,
  parameter int RDATA_W     = 32,
  parameter int RR_MODE     = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CLIENTS-1:0]         cl_req,
  output logic [NUM_CLIENTS-1:0]         cl_ack,
  input  logic [NUM_CLIENTS*ADDR_W-1:0]  cl_addr,
  input  logic [NUM_CLIENTS*16-1:0]      cl_wdata,
  input  logic [NUM_CLIENTS*2-1:0]       cl_be,
  input  logic [NUM_CLIENTS-1:0]         cl_rw,
  output logic [NUM_CLIENTS*RDATA_W-1:0] cl_q,
  output logic [ADDR_W-1:0]              sdr_addr,
  output logic [15:0]                    sdr_data,
  output logic [1:0]                     sdr_be,
  output logic                           sdr_rw,
  output logic                           sdr_req,
  input  logic                           sdr_ack,
  input  logic [RDATA_W-1:0]             sdr_q,
  output logic [2:0]                     grant_id,
  output logic                           busy
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t                     r_state;
  state_t                     w_next_state;

  logic [NUM_CLIENTS-1:0]         r_cl_ack;
  logic [NUM_CLIENTS*RDATA_W-1:0] r_cl_q;
  logic [ADDR_W-1:0]              r_sdr_addr;
  logic [15:0]                    r_sdr_data;
  logic [1:0]                     r_sdr_be;
  logic                           r_sdr_rw;
  logic                           r_sdr_req;
  logic [2:0]                     r_grant_id;
  logic [2:0]                     r_last;

  logic [NUM_CLIENTS-1:0] w_pending;
  logic                   w_any;
  logic [2:0]             w_win;
  logic                   w_issue;
  logic                   w_done;
  logic [ADDR_W-1:0]      w_sel_addr;
  logic [15:0]            w_sel_wdata;
  logic [1:0]             w_sel_be;
  logic                   w_sel_rw;

  assign w_pending = cl_req ^ r_cl_ack;
  assign w_any     = |w_pending;

  // Winner selection: lowest pending index, or first pending above the last grant.
  always_comb begin : p_winner
    int   idx;
    logic found;
    w_win = '0;
    idx   = 0;
    found = 1'b0;
    if (RR_MODE == 0) begin
      for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
        if (w_pending[i]) w_win = 3'(i);
      end
    end else begin
      for (int k = 1; k <= NUM_CLIENTS; k++) begin
        idx = (int'(r_last) + k) % NUM_CLIENTS;
        if (!found && w_pending[idx]) begin
          w_win = 3'(idx);
          found = 1'b1;
        end
      end
    end
  end

  // Field mux: pick the winning client's request fields out of the packed buses.
  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_be    = '0;
    w_sel_rw    = 1'b1;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (3'(i) == w_win) begin
        w_sel_addr  = cl_addr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = cl_wdata[i*16 +: 16];
        w_sel_be    = cl_be[i*2 +: 2];
        w_sel_rw    = cl_rw[i];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // FSM next state: IDLE issues whenever anyone is pending; WAIT ends on ack match.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next_state = S_WAIT;
      S_WAIT:  if (sdr_ack == r_sdr_req) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs: issue and completion strobes plus the busy flag.
  always_comb begin
    w_issue = (r_state == S_IDLE) && w_any;
    w_done  = (r_state == S_WAIT) && (sdr_ack == r_sdr_req);
    busy    = (r_state == S_WAIT);
  end

  // Datapath: latch request fields at grant, return read data and ack at completion.
  // Completion always returns to IDLE, so two issues are at least two edges apart.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cl_ack   <= '0;
      r_cl_q     <= '0;
      r_sdr_addr <= '0;
      r_sdr_data <= '0;
      r_sdr_be   <= '0;
      r_sdr_rw   <= 1'b1;
      r_sdr_req  <= 1'b0;
      r_grant_id <= '0;
      r_last     <= 3'(NUM_CLIENTS - 1);
    end else begin
      if (w_issue) begin
        r_sdr_addr <= w_sel_addr;
        r_sdr_data <= w_sel_wdata;
        r_sdr_be   <= w_sel_be;
        r_sdr_rw   <= w_sel_rw;
        r_sdr_req  <= ~r_sdr_req;
        r_grant_id <= w_win;
        r_last     <= w_win;
      end
      if (w_done) begin
        // Writes also load sdr_q; only the granted slice ever changes.
        for (int i = 0; i < NUM_CLIENTS; i++) begin
          if (3'(i) == r_grant_id) begin
            r_cl_q[i*RDATA_W +: RDATA_W] <= sdr_q;
            r_cl_ack[i]                  <= ~r_cl_ack[i];
          end
        end
      end
    end
  end

  assign cl_ack   = r_cl_ack;
  assign cl_q     = r_cl_q;
  assign sdr_addr = r_sdr_addr;
  assign sdr_data = r_sdr_data;
  assign sdr_be   = r_sdr_be;
  assign sdr_rw   = r_sdr_rw;
  assign sdr_req  = r_sdr_req;
  assign grant_id = r_grant_id;

endmodule

// File: tb/tb_sdram_client_arbiter.sv
// Directed bench for sdram_client_arbiter: instance a is fixed priority,
// instance b is round-robin; each has a toggle-handshake SDRAM responder model.
module tb_sdram_client_arbiter;

  localparam int NC = 3;
  localparam int AW = 26;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  // ---------------- instance a (fixed priority) ----------------
  logic [NC-1:0]    a_cl_req = '0;
  logic [NC-1:0]    a_cl_ack;
  logic [NC*AW-1:0] a_cl_addr = '0;
  logic [NC*16-1:0] a_cl_wdata = '0;
  logic [NC*2-1:0]  a_cl_be = '0;
  logic [NC-1:0]    a_cl_rw = '1;
  logic [NC*DW-1:0] a_cl_q;
  logic [AW-1:0]    a_sdr_addr;
  logic [15:0]      a_sdr_data;
  logic [1:0]       a_sdr_be;
  logic             a_sdr_rw;
  logic             a_sdr_req;
  logic             a_sdr_ack = 1'b0;
  logic [DW-1:0]    a_sdr_q = '0;
  logic [2:0]       a_grant_id;
  logic             a_busy;
  int               a_lat = 0;
  int               a_cnt = 0;
  logic [DW-1:0]    a_q_val = '0;

  // ---------------- instance b (round-robin) ----------------
  logic [NC-1:0]    b_cl_req = '0;
  logic [NC-1:0]    b_cl_ack;
  logic [NC*AW-1:0] b_cl_addr = '0;
  logic [NC*16-1:0] b_cl_wdata = '0;
  logic [NC*2-1:0]  b_cl_be = '0;
  logic [NC-1:0]    b_cl_rw = '1;
  logic [NC*DW-1:0] b_cl_q;
  logic [AW-1:0]    b_sdr_addr;
  logic [15:0]      b_sdr_data;
  logic [1:0]       b_sdr_be;
  logic             b_sdr_rw;
  logic             b_sdr_req;
  logic             b_sdr_ack = 1'b0;
  logic [DW-1:0]    b_sdr_q = '0;
  logic [2:0]       b_grant_id;
  logic             b_busy;

  sdram_client_arbiter #(.NUM_CLIENTS(NC), .ADDR_W(AW), .RDATA_W(DW), .RR_MODE(0)) dut_a (
    .clk(clk), .reset(reset),
    .cl_req(a_cl_req), .cl_ack(a_cl_ack), .cl_addr(a_cl_addr), .cl_wdata(a_cl_wdata),
    .cl_be(a_cl_be), .cl_rw(a_cl_rw), .cl_q(a_cl_q),
    .sdr_addr(a_sdr_addr), .sdr_data(a_sdr_data), .sdr_be(a_sdr_be), .sdr_rw(a_sdr_rw),
    .sdr_req(a_sdr_req), .sdr_ack(a_sdr_ack), .sdr_q(a_sdr_q),
    .grant_id(a_grant_id), .busy(a_busy)
  );

  sdram_client_arbiter #(.NUM_CLIENTS(NC), .ADDR_W(AW), .RDATA_W(DW), .RR_MODE(1)) dut_b (
    .clk(clk), .reset(reset),
    .cl_req(b_cl_req), .cl_ack(b_cl_ack), .cl_addr(b_cl_addr), .cl_wdata(b_cl_wdata),
    .cl_be(b_cl_be), .cl_rw(b_cl_rw), .cl_q(b_cl_q),
    .sdr_addr(b_sdr_addr), .sdr_data(b_sdr_data), .sdr_be(b_sdr_be), .sdr_rw(b_sdr_rw),
    .sdr_req(b_sdr_req), .sdr_ack(b_sdr_ack), .sdr_q(b_sdr_q),
    .grant_id(b_grant_id), .busy(b_busy)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // SDRAM model a: acks a_lat cycles after seeing a new request (0 = next edge completes).
  always @(posedge clk) begin
    #2;
    if (reset) begin
      a_sdr_ack = 1'b0;
      a_cnt     = 0;
    end else if (a_sdr_req != a_sdr_ack) begin
      if (a_cnt >= a_lat) begin
        a_sdr_ack = a_sdr_req;
        a_sdr_q   = a_q_val;
        a_cnt     = 0;
      end else begin
        a_cnt++;
      end
    end
  end

  // SDRAM model b: always fastest response.
  always @(posedge clk) begin
    #2;
    if (reset) begin
      b_sdr_ack = 1'b0;
    end else if (b_sdr_req != b_sdr_ack) begin
      b_sdr_ack = b_sdr_req;
      b_sdr_q   = 32'h5A5A_0000 + {29'd0, b_grant_id};
    end
  end

  // Absolute safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  // Wait until instance a leaves WAIT; n = negedges waited (50 means it never did).
  task automatic wait_a_idle(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (a_busy && n < 50);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    a_cl_req = '0;
    b_cl_req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (a_sdr_req !== 1'b0) begin errors++; $display("FAIL rst_sdr_req: got %0h want 0", a_sdr_req); end
    checks++; if (a_cl_ack !== 3'b000) begin errors++; $display("FAIL rst_cl_ack: got %b want 000", a_cl_ack); end
    checks++; if (a_sdr_rw !== 1'b1) begin errors++; $display("FAIL rst_sdr_rw: got %0h want 1", a_sdr_rw); end
    checks++; if ({a_sdr_addr, a_sdr_data, a_sdr_be} !== '0) begin errors++; $display("FAIL rst_sdr_fields: got %h/%h/%b want 0", a_sdr_addr, a_sdr_data, a_sdr_be); end
    checks++; if (a_cl_q !== '0) begin errors++; $display("FAIL rst_cl_q: got %h want 0", a_cl_q); end
    checks++; if (a_grant_id !== 3'd0 || a_busy !== 1'b0) begin errors++; $display("FAIL rst_grant_busy: got %0d/%0d want 0/0", a_grant_id, a_busy); end
    checks++; if (b_grant_id !== 3'd0 || b_busy !== 1'b0 || b_sdr_req !== 1'b0) begin errors++; $display("FAIL rst_b: got g=%0d busy=%0d req=%0d want 0/0/0", b_grant_id, b_busy, b_sdr_req); end
  endtask

  task automatic test_single_read();
    int n;
    a_lat = 4;
    a_q_val = 32'hDEAD_BEEF;
    a_cl_addr[1*AW +: AW] = 26'h000100;
    a_cl_rw[1] = 1'b1;
    a_cl_req[1] = ~a_cl_req[1];
    @(negedge clk);
    checks++; if (a_sdr_req !== 1'b1) begin errors++; $display("FAIL rd_sdr_req: got %0h want 1", a_sdr_req); end
    checks++; if (a_sdr_addr !== 26'h000100) begin errors++; $display("FAIL rd_sdr_addr: got %h want 000100", a_sdr_addr); end
    checks++; if (a_sdr_rw !== 1'b1) begin errors++; $display("FAIL rd_sdr_rw: got %0h want 1", a_sdr_rw); end
    checks++; if (a_grant_id !== 3'd1 || a_busy !== 1'b1) begin errors++; $display("FAIL rd_grant: got g=%0d busy=%0d want 1/1", a_grant_id, a_busy); end
    checks++; if (a_cl_ack !== 3'b000) begin errors++; $display("FAIL rd_early_ack: got %b want 000", a_cl_ack); end
    wait_a_idle(n);
    checks++; if (n !== 5) begin errors++; $display("FAIL rd_latency: got %0d cycles want 5", n); end
    checks++; if (a_cl_ack !== 3'b010) begin errors++; $display("FAIL rd_cl_ack: got %b want 010", a_cl_ack); end
    checks++; if (a_cl_q[1*DW +: DW] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_cl_q1: got %h want deadbeef", a_cl_q[1*DW +: DW]); end
    checks++; if (a_cl_q[0 +: DW] !== '0 || a_cl_q[2*DW +: DW] !== '0) begin errors++; $display("FAIL rd_other_q: got %h want 0 in slices 0,2", a_cl_q); end
  endtask

  task automatic test_write();
    int n;
    a_lat = 1;
    a_q_val = 32'hCAFE_0001;
    a_cl_addr[0 +: AW] = 26'h0002A0;
    a_cl_wdata[0 +: 16] = 16'h1234;
    a_cl_be[0 +: 2] = 2'b01;
    a_cl_rw[0] = 1'b0;
    a_cl_req[0] = ~a_cl_req[0];
    @(negedge clk);
    checks++; if (a_sdr_data !== 16'h1234 || a_sdr_be !== 2'b01 || a_sdr_rw !== 1'b0) begin errors++; $display("FAIL wr_fields: got d=%h be=%b rw=%0d want 1234/01/0", a_sdr_data, a_sdr_be, a_sdr_rw); end
    checks++; if (a_grant_id !== 3'd0 || a_sdr_req !== 1'b0) begin errors++; $display("FAIL wr_grant: got g=%0d req=%0d want 0/0", a_grant_id, a_sdr_req); end
    wait_a_idle(n);
    checks++; if (n !== 2) begin errors++; $display("FAIL wr_latency: got %0d want 2", n); end
    checks++; if (a_cl_ack !== 3'b011) begin errors++; $display("FAIL wr_cl_ack: got %b want 011", a_cl_ack); end
    checks++; if (a_cl_q[0 +: DW] !== 32'hCAFE_0001) begin errors++; $display("FAIL wr_cl_q0: got %h want cafe0001", a_cl_q[0 +: DW]); end
    checks++; if (a_cl_q[1*DW +: DW] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_cl_q1_kept: got %h want deadbeef", a_cl_q[1*DW +: DW]); end
    a_cl_rw[0] = 1'b1;
  endtask

  task automatic test_fixed_priority();
    int n;
    a_lat = 2;
    a_q_val = 32'h0000_00F0;
    a_cl_addr[0 +: AW] = 26'h000AA0;
    a_cl_addr[2*AW +: AW] = 26'h000CC0;
    a_cl_req[0] = ~a_cl_req[0];
    a_cl_req[2] = ~a_cl_req[2];
    @(negedge clk);
    checks++; if (a_grant_id !== 3'd0 || a_sdr_addr !== 26'h000AA0) begin errors++; $display("FAIL fp_first: got g=%0d addr=%h want 0/000aa0", a_grant_id, a_sdr_addr); end
    wait_a_idle(n);
    checks++; if (n !== 3) begin errors++; $display("FAIL fp_latency: got %0d want 3", n); end
    @(negedge clk);
    checks++; if (a_grant_id !== 3'd2 || a_sdr_addr !== 26'h000CC0 || a_busy !== 1'b1) begin errors++; $display("FAIL fp_second: got g=%0d addr=%h busy=%0d want 2/000cc0/1", a_grant_id, a_sdr_addr, a_busy); end
    wait_a_idle(n);
    checks++; if (a_cl_ack !== 3'b110) begin errors++; $display("FAIL fp_cl_ack: got %b want 110", a_cl_ack); end
    checks++; if (a_cl_q[2*DW +: DW] !== 32'h0000_00F0) begin errors++; $display("FAIL fp_cl_q2: got %h want 000000f0", a_cl_q[2*DW +: DW]); end
  endtask

  task automatic test_back_to_back();
    int n;
    a_lat = 0;
    a_cl_addr[0 +: AW] = 26'h000111;
    a_cl_addr[1*AW +: AW] = 26'h000222;
    a_cl_req[0] = ~a_cl_req[0];
    a_cl_req[1] = ~a_cl_req[1];
    @(negedge clk);
    checks++; if (a_sdr_req !== 1'b1 || a_grant_id !== 3'd0 || a_sdr_addr !== 26'h000111) begin errors++; $display("FAIL b2b_grant0: got req=%0d g=%0d addr=%h want 1/0/000111", a_sdr_req, a_grant_id, a_sdr_addr); end
    a_cl_addr[0 +: AW] = 26'h3FFFFFF;
    @(negedge clk);
    checks++; if (a_sdr_req !== 1'b1 || a_busy !== 1'b0 || a_sdr_addr !== 26'h000111) begin errors++; $display("FAIL b2b_gap: got req=%0d busy=%0d addr=%h want 1/0/000111", a_sdr_req, a_busy, a_sdr_addr); end
    @(negedge clk);
    checks++; if (a_sdr_req !== 1'b0 || a_grant_id !== 3'd1 || a_sdr_addr !== 26'h000222) begin errors++; $display("FAIL b2b_grant1: got req=%0d g=%0d addr=%h want 0/1/000222", a_sdr_req, a_grant_id, a_sdr_addr); end
    wait_a_idle(n);
    checks++; if (a_cl_ack !== 3'b101) begin errors++; $display("FAIL b2b_cl_ack: got %b want 101", a_cl_ack); end
  endtask

  task automatic test_reset_mid_access();
    int n;
    do_reset();
    a_lat = 10;
    a_q_val = 32'h0BAD_F00D;
    a_cl_addr[1*AW +: AW] = 26'h0ABCDE;
    a_cl_req[1] = 1'b1;
    @(negedge clk);
    checks++; if (a_busy !== 1'b1 || a_grant_id !== 3'd1) begin errors++; $display("FAIL rm_grant: got busy=%0d g=%0d want 1/1", a_busy, a_grant_id); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (a_sdr_req !== 1'b0 || a_cl_ack !== 3'b000 || a_busy !== 1'b0) begin errors++; $display("FAIL rm_abandon: got req=%0d ack=%b busy=%0d want 0/000/0", a_sdr_req, a_cl_ack, a_busy); end
    checks++; if (a_sdr_addr !== '0 || a_cl_q !== '0) begin errors++; $display("FAIL rm_cleared: got addr=%h q=%h want 0/0", a_sdr_addr, a_cl_q); end
    a_lat = 1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (a_grant_id !== 3'd1 || a_busy !== 1'b1 || a_sdr_req !== 1'b1 || a_sdr_addr !== 26'h0ABCDE) begin errors++; $display("FAIL rm_reserve: got g=%0d busy=%0d req=%0d addr=%h want 1/1/1/0abcde", a_grant_id, a_busy, a_sdr_req, a_sdr_addr); end
    wait_a_idle(n);
    checks++; if (a_cl_ack !== 3'b010 || a_cl_q[1*DW +: DW] !== 32'h0BAD_F00D) begin errors++; $display("FAIL rm_complete: got ack=%b q1=%h want 010/0badf00d", a_cl_ack, a_cl_q[1*DW +: DW]); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [6];
    logic [2:0] got_g [6];
    logic       prev;
    int         ng;
    int         cyc;
    exp_g[0] = 3'd0; exp_g[1] = 3'd1; exp_g[2] = 3'd2;
    exp_g[3] = 3'd0; exp_g[4] = 3'd1; exp_g[5] = 3'd2;
    for (int i = 0; i < 6; i++) got_g[i] = 3'd7;
    ng = 0;
    cyc = 0;
    @(negedge clk);
    prev = b_sdr_req;
    b_cl_req = ~b_cl_ack;
    while (ng < 6 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (b_sdr_req != prev) begin
        got_g[ng] = b_grant_id;
        ng++;
        prev = b_sdr_req;
      end
      for (int i = 0; i < NC; i++) begin
        if (b_cl_ack[i] == b_cl_req[i]) b_cl_req[i] = ~b_cl_req[i];
      end
    end
    checks++; if (ng !== 6) begin errors++; $display("FAIL rr_count: got %0d grants want 6", ng); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (got_g[i] !== exp_g[i]) begin errors++; $display("FAIL rr_seq[%0d]: got %0d want %0d", i, got_g[i], exp_g[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_fixed_priority();
    test_back_to_back();
    test_reset_mid_access();
    test_round_robin();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
